// File: rtl/mem_bus_port.sv
// Memory-side bus endpoint: owns MAR/MDR and runs a req/ack
// transaction with the word-addressed RAM.
module mem_bus_port #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] BusMuxInMDR,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic [CNT_W-1:0]  cnt;

  assign busy        = (state != IDLE);
  assign mem_addr    = mar;
  assign mem_wdata   = mdr;
  assign BusMuxInMDR = mdr;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= IDLE;
      mar     <= '0;
      mdr     <= '0;
      cnt     <= '0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (MARin) mar <= BusMuxOut[ADDR_W-1:0];
          if (MDRin) mdr <= BusMuxOut;
          // Read wins when both strobes arrive together
          if (Read || Write) begin
            state   <= REQ;
            mem_req <= 1'b1;
            mem_we  <= Write & ~Read;
            err     <= 1'b0;
            cnt     <= '0;
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (!mem_we) mdr <= mem_rdata;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else if (cnt == CNT_LAST) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err     <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
